// File: rtl/gtfwizard_0_example_drp_responder_pkg.sv
// Shared DRP widths, FSM state encoding and parameter legality helpers
// for the example DRP responder.
package gtfwizard_0_example_drp_responder_pkg;

    localparam int DRP_ADDR_W = 10;
    localparam int DRP_DATA_W = 16;
    localparam int REG_IDX_W  = 6;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_WAIT_ENC = 2'd1;
    localparam logic [1:0] ST_RESP_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_WAIT = ST_WAIT_ENC,
        ST_RESP = ST_RESP_ENC
    } state_t;

    function automatic bit latency_legal(input int lat);
        return (lat >= 1) && (lat <= 15);
    endfunction

    function automatic bit num_regs_legal(input int n);
        return (n >= 1) && (n <= 64);
    endfunction

endpackage

// File: rtl/gtfwizard_0_example_drp_responder_if.sv
// DRP request/response bundle; master is the initiator, slave the responder.
interface gtfwizard_0_example_drp_responder_if;
    import gtfwizard_0_example_drp_responder_pkg::*;

    logic                  drpen_in;
    logic                  drpwe_in;
    logic [DRP_ADDR_W-1:0] drpaddr_in;
    logic [DRP_DATA_W-1:0] drpdi_in;
    logic                  drprdy_out;
    logic [DRP_DATA_W-1:0] drpdo_out;

    modport master (
        output drpen_in, drpwe_in, drpaddr_in, drpdi_in,
        input  drprdy_out, drpdo_out
    );

    modport slave (
        input  drpen_in, drpwe_in, drpaddr_in, drpdi_in,
        output drprdy_out, drpdo_out
    );

endinterface

// File: rtl/gtfwizard_0_example_drp_responder_regbank.sv
// Register bank behind the DRP responder: storage, single write port,
// combinational read mux and flat view of all words.
module gtfwizard_0_example_drp_responder_regbank
    import gtfwizard_0_example_drp_responder_pkg::*;
#(
    parameter int                    NUM_REGS  = 16,
    parameter logic [DRP_DATA_W-1:0] RESET_VAL = 16'h0000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [REG_IDX_W-1:0]           wr_idx,
    input  logic [DRP_DATA_W-1:0]          wr_data,
    input  logic [REG_IDX_W-1:0]           rd_idx,
    output logic [DRP_DATA_W-1:0]          rd_data,
    output logic [DRP_DATA_W*NUM_REGS-1:0] regs_flat
);

    logic [NUM_REGS-1:0][DRP_DATA_W-1:0] bank_q;
    logic [NUM_REGS-1:0][DRP_DATA_W-1:0] bank_d;

    // Index compares are done per word so an index beyond NUM_REGS never selects anything.
    always_comb begin
        bank_d  = bank_q;
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (wr_idx == REG_IDX_W'(i))) begin
                bank_d[i] = wr_data;
            end
            if (rd_idx == REG_IDX_W'(i)) begin
                rd_data = bank_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= {NUM_REGS{RESET_VAL}};
        end else begin
            bank_q <= bank_d;
        end
    end

    assign regs_flat = bank_q;

endmodule

// File: rtl/gtfwizard_0_example_drp_responder.sv
// DRP target with a fixed response latency, a soft register bank and
// sticky/pulsed protocol error flags.
module gtfwizard_0_example_drp_responder
    import gtfwizard_0_example_drp_responder_pkg::*;
#(
    parameter logic [DRP_ADDR_W-1:0] BASE_ADDR = 10'h080,
    parameter int                    NUM_REGS  = 16,
    parameter logic [DRP_DATA_W-1:0] RESET_VAL = 16'h0000,
    parameter int                    LATENCY   = 3
) (
    input  logic                                  freerun_clk_in,
    input  logic                                  drp_reset_in,
    gtfwizard_0_example_drp_responder_if.slave    drp,
    input  logic                                  err_clear_in,
    output logic                                  busy_out,
    output logic                                  proto_err_out,
    output logic                                  range_err_out,
    output logic [DRP_DATA_W*NUM_REGS-1:0]        regs_flat_out
);

    if (!latency_legal(LATENCY)) begin : g_bad_latency
        $error("LATENCY must be in 1..15");
    end
    if (!num_regs_legal(NUM_REGS)) begin : g_bad_num_regs
        $error("NUM_REGS must be in 1..64");
    end

    function automatic logic in_bank(input logic [DRP_ADDR_W-1:0] a);
        logic [DRP_ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < (DRP_ADDR_W+1)'(NUM_REGS));
    endfunction

    function automatic logic [REG_IDX_W-1:0] bank_idx(input logic [DRP_ADDR_W-1:0] a);
        return REG_IDX_W'(a - BASE_ADDR);
    endfunction

    state_t                state_q,     state_d;
    logic [3:0]            cnt_q,       cnt_d;
    logic [DRP_ADDR_W-1:0] addr_q,      addr_d;
    logic                  we_q,        we_d;
    logic [DRP_DATA_W-1:0] di_q,        di_d;
    logic                  rdy_q,       rdy_d;
    logic [DRP_DATA_W-1:0] do_q,        do_d;
    logic                  busy_q,      busy_d;
    logic                  proto_q,     proto_d;
    logic                  range_err_q, range_err_d;

    logic                  wr_en;
    logic [DRP_DATA_W-1:0] rd_data;

    // Outputs are computed from the next state so they are registered and land in the RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        di_d    = di_q;
        case (state_q)
            ST_IDLE: begin
                if (drp.drpen_in) begin
                    addr_d  = drp.drpaddr_in;
                    we_d    = drp.drpwe_in;
                    di_d    = drp.drpdi_in;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        rdy_d       = (state_d == ST_RESP);
        range_err_d = rdy_d && !in_bank(addr_d);
        do_d        = (rdy_d && !we_d && in_bank(addr_d)) ? rd_data : '0;
        busy_d      = (state_d != ST_IDLE);

        if (drp.drpen_in && (state_q != ST_IDLE)) begin
            proto_d = 1'b1;
        end else if (err_clear_in) begin
            proto_d = 1'b0;
        end else begin
            proto_d = proto_q;
        end
    end

    always_ff @(posedge freerun_clk_in or posedge drp_reset_in) begin
        if (drp_reset_in) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            di_q        <= '0;
            rdy_q       <= 1'b0;
            do_q        <= '0;
            busy_q      <= 1'b0;
            proto_q     <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            di_q        <= di_d;
            rdy_q       <= rdy_d;
            do_q        <= do_d;
            busy_q      <= busy_d;
            proto_q     <= proto_d;
            range_err_q <= range_err_d;
        end
    end

    assign wr_en = (state_q == ST_RESP) && we_q && in_bank(addr_q);

    gtfwizard_0_example_drp_responder_regbank #(
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL)
    ) u_regbank (
        .clk       (freerun_clk_in),
        .rst       (drp_reset_in),
        .wr_en     (wr_en),
        .wr_idx    (bank_idx(addr_q)),
        .wr_data   (di_q),
        .rd_idx    (bank_idx(addr_d)),
        .rd_data   (rd_data),
        .regs_flat (regs_flat_out)
    );

    assign drp.drprdy_out = rdy_q;
    assign drp.drpdo_out  = do_q;
    assign busy_out       = busy_q;
    assign proto_err_out  = proto_q;
    assign range_err_out  = range_err_q;

endmodule

// File: tb/tb_gtfwizard_0_example_drp_responder.sv
// Self-checking bench for the DRP responder: directed scenarios plus
// randomized transactions against an array-based model of the bank.
module tb_gtfwizard_0_example_drp_responder;

    localparam int          LAT   = 3;
    localparam int          NREGS = 16;
    localparam int          BASE  = 128;
    localparam logic [15:0] RVAL  = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err_clear = 1'b0;
    logic        busy, proto_err, range_err;
    logic [255:0] regs_flat;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mdl [NREGS];

    gtfwizard_0_example_drp_responder_if bus ();

    gtfwizard_0_example_drp_responder dut (
        .freerun_clk_in (clk),
        .drp_reset_in   (rst),
        .drp            (bus),
        .err_clear_in   (err_clear),
        .busy_out       (busy),
        .proto_err_out  (proto_err),
        .range_err_out  (range_err),
        .regs_flat_out  (regs_flat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit mdl_in_range(input logic [9:0] a);
        return (int'(a) >= BASE) && (int'(a) < BASE + NREGS);
    endfunction

    function automatic logic [255:0] mdl_flat();
        logic [255:0] f;
        for (int i = 0; i < NREGS; i++) f[16*i +: 16] = mdl[i];
        return f;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < NREGS; i++) mdl[i] = RVAL;
    endtask

    // Issues one request, waits for the completion and returns what the
    // responder reported; ends in the cycle after drprdy.
    task automatic txn(input bit we, input logic [9:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output int lat, output logic rerr);
        bus.drpen_in   = 1'b1;
        bus.drpwe_in   = we;
        bus.drpaddr_in = a;
        bus.drpdi_in   = d;
        step();
        bus.drpen_in   = 1'b0;
        bus.drpwe_in   = 1'($urandom);
        bus.drpaddr_in = 10'($urandom);
        bus.drpdi_in   = 16'($urandom);
        lat = 0; rd = '0; rerr = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) chk("busy_after_accept", busy, 1'b1);
            if (bus.drprdy_out) begin
                lat = k; rd = bus.drpdo_out; rerr = range_err;
                break;
            end
            if (bus.drpdo_out !== 16'h0000) chk("drpdo_idle_zero", bus.drpdo_out, 16'h0000);
            step();
        end
        if (lat != 0) step();
        chk("rdy_single_pulse", bus.drprdy_out, 1'b0);
        if (we) begin
            if (mdl_in_range(a)) mdl[int'(a) - BASE] = d;
        end
    endtask

    task automatic do_check_txn(input string tag, input bit we, input logic [9:0] a,
                                input logic [15:0] d);
        logic [15:0] exp_rd, rd;
        logic        exp_rerr, rerr;
        int          lat;
        exp_rd   = (!we && mdl_in_range(a)) ? mdl[int'(a) - BASE] : 16'h0000;
        exp_rerr = !mdl_in_range(a);
        txn(we, a, d, rd, lat, rerr);
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_data"}, rd, exp_rd);
        chk({tag, "_rerr"}, rerr, exp_rerr);
        chk({tag, "_flat"}, regs_flat, mdl_flat());
    endtask

    initial begin
        int          rdy_cnt;
        logic [15:0] rd;
        int          lat;
        logic        rerr;

        bus.drpen_in = 1'b0; bus.drpwe_in = 1'b0;
        bus.drpaddr_in = '0; bus.drpdi_in = '0;
        mdl_reset();
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("reset_busy", busy, 1'b0);
        chk("reset_proto", proto_err, 1'b0);
        chk("reset_range", range_err, 1'b0);
        chk("reset_rdy", bus.drprdy_out, 1'b0);
        chk("reset_do", bus.drpdo_out, 16'h0000);
        chk("reset_flat", regs_flat, mdl_flat());

        do_check_txn("rd_08a", 1'b0, 10'h08A, 16'h0);
        do_check_txn("wr_08a", 1'b1, 10'h08A, 16'h4001);
        do_check_txn("rb_08a", 1'b0, 10'h08A, 16'h0);
        chk("word10", regs_flat[175:160], 16'h4001);

        // Read-modify-write flipping bit 14
        txn(1'b0, 10'h08A, 16'h0, rd, lat, rerr);
        chk("rmw_read", rd, 16'h4001);
        do_check_txn("rmw_wr", 1'b1, 10'h08A, rd ^ 16'h4000);
        chk("rmw_word", regs_flat[175:160], 16'h0001);
        chk("rmw_proto", proto_err, 1'b0);

        do_check_txn("oor_wr_100", 1'b1, 10'h100, 16'hDEAD);
        do_check_txn("oor_rd_07f", 1'b0, 10'h07F, 16'h0);

        // Request while busy: ignored, sets sticky error
        bus.drpen_in = 1'b1; bus.drpwe_in = 1'b0; bus.drpaddr_in = 10'h081;
        step();
        bus.drpen_in = 1'b1; bus.drpwe_in = 1'b1; bus.drpaddr_in = 10'h082; bus.drpdi_in = 16'h1234;
        step();
        bus.drpen_in = 1'b0;
        chk("viol_proto_set", proto_err, 1'b1);
        rdy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.drprdy_out) rdy_cnt++;
            step();
        end
        chk("viol_one_rdy", rdy_cnt, 1);
        chk("viol_flat", regs_flat, mdl_flat());
        chk("viol_proto_sticky", proto_err, 1'b1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("viol_proto_clr", proto_err, 1'b0);

        // Clear and new violation in the same cycle: set wins
        bus.drpen_in = 1'b1; bus.drpwe_in = 1'b0; bus.drpaddr_in = 10'h083;
        step();
        err_clear = 1'b1;
        step();
        bus.drpen_in = 1'b0; err_clear = 1'b0;
        chk("set_wins", proto_err, 1'b1);
        repeat (6) step();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("set_wins_clr", proto_err, 1'b0);

        // Reset while waiting on a write
        bus.drpen_in = 1'b1; bus.drpwe_in = 1'b1; bus.drpaddr_in = 10'h08F; bus.drpdi_in = 16'hBEEF;
        step();
        bus.drpen_in = 1'b0;
        step();
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        mdl_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_flat", regs_flat, mdl_flat());
        step();
        rst = 1'b0;
        rdy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.drprdy_out) rdy_cnt++;
            step();
        end
        chk("rst_no_rdy", rdy_cnt, 0);
        chk("rst_word15", regs_flat[255:240], RVAL);
        chk("rst_busy_after", busy, 1'b0);

        // Randomized traffic around the bank window
        for (int n = 0; n < 150; n++) begin
            logic [9:0]  a;
            logic [15:0] d;
            bit          we;
            if ($urandom_range(0, 3) == 0) a = 10'($urandom);
            else a = 10'(10'h078 + 10'($urandom_range(0, 31)));
            we = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            do_check_txn("rand", we, a, d);
            repeat ($urandom_range(0, 2)) step();
        end
        chk("rand_proto", proto_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
